csr_file: RTL and testbench
===========================

CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 Parameter MXLEN, 32, width of every CSR and data port.
REQ-002 Parameter MTVEC_RESET, 32'h0000_0000, reset value of mtvec.
REQ-003 Parameter MHARTID, 32'h0, read-only value of mhartid.
REQ-004 i_clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 i_rst  in  1  reset, asynchronous and active-high.
REQ-006 i_csr_en  in  1  a CSR instruction is executing this cycle.
REQ-007 i_csr_op  in  2  01 write, 10 set, 11 clear, 00 read-only.
REQ-008 i_csr_addr  in  12  CSR address.
REQ-009 i_csr_wdata  in  MXLEN  operand (rs1 value or zero-extended zimm).
REQ-010 i_csr_no_wr  in  1  set/clear with rs1/zimm = x0; suppresses the write and the read-only check.
REQ-011 i_retire  in  1  the current instruction retires this cycle.
REQ-012 i_trap_req  in  1  trap taken this cycle.
REQ-013 i_trap_cause  in  MXLEN  value for mcause.
REQ-014 i_trap_pc  in  MXLEN  faulting pc, value for mepc.
REQ-015 i_trap_tval  in  MXLEN  value for mtval.
REQ-016 i_mret  in  1  MRET is executing this cycle.
REQ-017 o_csr_rdata  out  MXLEN  old value of the addressed CSR, combinational.
REQ-018 o_t_illegal_csr  out  1  illegal CSR access, combinational.
REQ-019 o_mtvec  out  MXLEN  current mtvec, with bits [1:0] = 00.
REQ-020 o_mepc  out  MXLEN  current mepc, used as the MRET target.
REQ-021 o_mie  out  1  mstatus.MIE.

Function
REQ-022 Implemented CSRs:
- mstatus 0x300: MIE bit 3, MPIE bit 7, MPP [12:11] hardwired to 11; other bits read 0.
- misa 0x301: read-only, 32'h4000_0100.
- mtvec 0x305.
- mscratch 0x340.
- mepc 0x341.
- mcause 0x342.
- mtval 0x343.
- mcycle/mcycleh 0xB00/0xB80.
- minstret/minstreth 0xB02/0xB82.
- mhartid 0xF14.
REQ-023 New value on write (op 01) = wdata; set (op 10) = old | wdata; clear (op 11) = old & ~wdata; committed at the next edge only if i_csr_en=1, no illegal access, i_csr_no_wr=0, op!=00, and i_trap_req=0.
REQ-024 o_t_illegal_csr = i_csr_en & (unimplemented address, or write attempted to addr[11:10]=11 or to misa).
REQ-025 mtvec bits [1:0] and mepc bits [1:0] are stored as 0 regardless of the written value.
REQ-026 Trap entry on i_trap_req=1, at the next edge:
- mepc <= i_trap_pc with [1:0] cleared.
- mcause <= i_trap_cause.
- mtval <= i_trap_tval.
- MPIE <= MIE.
- MIE <= 0.
REQ-027 On i_mret=1 with i_trap_req=0, at the next edge: MIE <= MPIE, MPIE <= 1.
REQ-028 Priority: i_trap_req over i_mret and over any CSR write in the same cycle; the dropped operations have no effect.
REQ-029 mcycle is 64-bit and increments by 1 every cycle out of reset.
REQ-030 minstret is 64-bit and increments by 1 when i_retire=1 and i_trap_req=0.
REQ-031 Both counters wrap from 2^64-1 to 0 with no flag.
REQ-032 A CSR write to either 32-bit half of a counter replaces that half and suppresses that counter's increment for the cycle; the other half is held.
REQ-033 A low-half increment carries into the high half.
REQ-034 o_csr_rdata returns the pre-update value, so a read and a write of the same CSR in one cycle read the old value.
REQ-035 When i_csr_en=0 or the access is illegal, o_csr_rdata = 0.
REQ-036 Latency: CSR writes, trap entry and MRET effects are visible on outputs one cycle after the enabling edge.

Reset
REQ-037 While i_rst=1, asynchronously and independent of the clock:
- mstatus = 32'h0000_1800.
- mtvec = MTVEC_RESET.
- mscratch, mepc, mcause, mtval, mcycle, minstret = 0.
- o_mie = 0.
REQ-038 Reset asserted in the same cycle as a trap, MRET or CSR write discards that operation.
REQ-039 The first mcycle increment occurs on the first rising edge after i_rst deasserts.

Verification
REQ-040 CSRRW 0x340 wdata 32'hDEAD_BEEF, then CSRRS 0x340 wdata 0 no_wr=1 -> first rdata 0, second rdata 32'hDEAD_BEEF, mscratch unchanged.
REQ-041 Write mtvec 32'h0000_0103 -> o_mtvec = 32'h0000_0100.
REQ-042 Set MIE, then i_trap_req with pc 32'h0000_0042, cause 2, tval 32'h0000_0013 -> mepc = 32'h40, mcause = 2, mtval = 32'h13, MIE = 0, MPIE = 1.
REQ-043 Then i_mret -> MIE = 1, MPIE = 1.
REQ-044 CSRRW 0xF14 -> o_t_illegal_csr = 1 and no state change; CSRRS 0xF14 no_wr=1 -> rdata = MHARTID, o_t_illegal_csr = 0.
REQ-045 Write mcycle 32'hFFFF_FFFF -> next cycle mcycleh reads 0; one cycle later mcycle reads 0 and mcycleh reads 1.
REQ-046 Trap and CSRRW mscratch in the same cycle -> mscratch unchanged.
REQ-047 Reset pulsed mid-run -> all registers return to their REQ-037 values immediately.

Source files
------------

// File: rtl/csr_file.sv
// Machine-mode CSR file: mstatus/misa/mtvec/mscratch/mepc/mcause/mtval/mhartid
// plus 64-bit mcycle and minstret counters, with trap entry and MRET handling.
module csr_file #(
    parameter int unsigned        MXLEN       = 32,
    parameter logic [MXLEN-1:0]   MTVEC_RESET = 32'h0000_0000,
    parameter logic [MXLEN-1:0]   MHARTID     = 32'h0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_csr_en,
    input  logic [1:0]       i_csr_op,
    input  logic [11:0]      i_csr_addr,
    input  logic [MXLEN-1:0] i_csr_wdata,
    input  logic             i_csr_no_wr,
    input  logic             i_retire,
    input  logic             i_trap_req,
    input  logic [MXLEN-1:0] i_trap_cause,
    input  logic [MXLEN-1:0] i_trap_pc,
    input  logic [MXLEN-1:0] i_trap_tval,
    input  logic             i_mret,
    output logic [MXLEN-1:0] o_csr_rdata,
    output logic             o_t_illegal_csr,
    output logic [MXLEN-1:0] o_mtvec,
    output logic [MXLEN-1:0] o_mepc,
    output logic             o_mie
);

    localparam int unsigned CW = 2 * MXLEN;

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MTVAL     = 12'h343;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

    localparam logic [MXLEN-1:0] MISA_VAL   = MXLEN'(32'h4000_0100);
    localparam logic [MXLEN-1:0] ALIGN_MASK = ~MXLEN'(3);
    localparam logic [MXLEN-1:0] MTVEC_RST  = MTVEC_RESET & ALIGN_MASK;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_SET   = 2'b10,
        OP_CLEAR = 2'b11
    } csr_op_e;

    logic             mie_q, mie_d;
    logic             mpie_q, mpie_d;
    logic [MXLEN-1:0] mtvec_q, mtvec_d;
    logic [MXLEN-1:0] mscratch_q, mscratch_d;
    logic [MXLEN-1:0] mepc_q, mepc_d;
    logic [MXLEN-1:0] mcause_q, mcause_d;
    logic [MXLEN-1:0] mtval_q, mtval_d;
    logic [CW-1:0]    mcycle_q, mcycle_d;
    logic [CW-1:0]    minstret_q, minstret_d;

    logic [MXLEN-1:0] rd_raw;
    logic [MXLEN-1:0] wval;
    logic             addr_ok;
    logic             wr_attempt;
    logic             illegal;
    logic             csr_we;

    // Read mux and access legality
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        rd_raw  = '0;
        addr_ok = 1'b1;
        unique case (i_csr_addr)
            ADDR_MSTATUS: begin
                rd_raw[12:11] = 2'b11;
                rd_raw[7]     = mpie_q;
                rd_raw[3]     = mie_q;
            end
            ADDR_MISA:      rd_raw = MISA_VAL;
            ADDR_MTVEC:     rd_raw = mtvec_q;
            ADDR_MSCRATCH:  rd_raw = mscratch_q;
            ADDR_MEPC:      rd_raw = mepc_q;
            ADDR_MCAUSE:    rd_raw = mcause_q;
            ADDR_MTVAL:     rd_raw = mtval_q;
            ADDR_MCYCLE:    rd_raw = mcycle_q[MXLEN-1:0];
            ADDR_MCYCLEH:   rd_raw = mcycle_q[CW-1:MXLEN];
            ADDR_MINSTRET:  rd_raw = minstret_q[MXLEN-1:0];
            ADDR_MINSTRETH: rd_raw = minstret_q[CW-1:MXLEN];
            ADDR_MHARTID:   rd_raw = MHARTID;
            default:        addr_ok = 1'b0;
        endcase

        wr_attempt = (i_csr_op != OP_READ) && !i_csr_no_wr;
        illegal    = i_csr_en && (!addr_ok ||
                     (wr_attempt && (i_csr_addr[11:10] == 2'b11 || i_csr_addr == ADDR_MISA)));
        csr_we     = i_csr_en && !illegal && wr_attempt && !i_trap_req;

        unique case (csr_op_e'(i_csr_op))
            OP_WRITE: wval = i_csr_wdata;
            OP_SET:   wval = rd_raw | i_csr_wdata;
            OP_CLEAR: wval = rd_raw & ~i_csr_wdata;
            default:  wval = rd_raw;
        endcase
    end

    // Next-state: trap beats MRET and CSR writes; MRET beats a same-cycle mstatus write
    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        mcycle_d   = mcycle_q + CW'(1);
        minstret_d = (i_retire && !i_trap_req) ? minstret_q + CW'(1) : minstret_q;

        if (csr_we) begin
            unique case (i_csr_addr)
                ADDR_MSTATUS: begin
                    mie_d  = wval[3];
                    mpie_d = wval[7];
                end
                ADDR_MTVEC:     mtvec_d    = wval & ALIGN_MASK;
                ADDR_MSCRATCH:  mscratch_d = wval;
                ADDR_MEPC:      mepc_d     = wval & ALIGN_MASK;
                ADDR_MCAUSE:    mcause_d   = wval;
                ADDR_MTVAL:     mtval_d    = wval;
                ADDR_MCYCLE:    mcycle_d   = {mcycle_q[CW-1:MXLEN], wval};
                ADDR_MCYCLEH:   mcycle_d   = {wval, mcycle_q[MXLEN-1:0]};
                ADDR_MINSTRET:  minstret_d = {minstret_q[CW-1:MXLEN], wval};
                ADDR_MINSTRETH: minstret_d = {wval, minstret_q[MXLEN-1:0]};
                default: ;
            endcase
        end

        if (i_trap_req) begin
            mepc_d   = i_trap_pc & ALIGN_MASK;
            mcause_d = i_trap_cause;
            mtval_d  = i_trap_tval;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (i_mret) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= MTVEC_RST;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    assign o_csr_rdata     = (i_csr_en && !illegal) ? rd_raw : '0;
    assign o_t_illegal_csr = illegal;
    assign o_mtvec         = mtvec_q;
    assign o_mepc          = mepc_q;
    assign o_mie           = mie_q;

endmodule

// File: tb/tb_csr_file.sv
// Scoreboard bench for csr_file: stimulus pushes expected values tagged with the
// cycle they apply to; a negedge monitor pops and compares them.
module tb_csr_file;

    localparam logic [31:0] MTVEC_RST = 32'h8000_0000;
    localparam logic [31:0] HARTID    = 32'h0000_0005;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        csr_en, csr_no_wr, retire, trap_req, mret;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, trap_cause, trap_pc, trap_tval;
    logic [31:0] csr_rdata, mtvec, mepc;
    logic        ill, mie;

    csr_file #(.MXLEN(32), .MTVEC_RESET(MTVEC_RST), .MHARTID(HARTID)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_csr_en(csr_en), .i_csr_op(csr_op), .i_csr_addr(csr_addr),
        .i_csr_wdata(csr_wdata), .i_csr_no_wr(csr_no_wr),
        .i_retire(retire), .i_trap_req(trap_req), .i_trap_cause(trap_cause),
        .i_trap_pc(trap_pc), .i_trap_tval(trap_tval), .i_mret(mret),
        .o_csr_rdata(csr_rdata), .o_t_illegal_csr(ill),
        .o_mtvec(mtvec), .o_mepc(mepc), .o_mie(mie)
    );

    always #5 clk = ~clk;

    typedef enum logic [2:0] {K_RDATA, K_ILL, K_MTVEC, K_MEPC, K_MIE} kind_e;
    typedef struct {
        int          cyc;
        kind_e       kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          finish_req = 1'b0;
    exp_t        mon_item;
    logic [31:0] act;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation due in the current cycle
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_item = sb.pop_front();
            case (mon_item.kind)
                K_RDATA: act = csr_rdata;
                K_ILL:   act = {31'b0, ill};
                K_MTVEC: act = mtvec;
                K_MEPC:  act = mepc;
                default: act = {31'b0, mie};
            endcase
            checks++;
            if (mon_item.cyc != cyc || act !== mon_item.val) begin
                errors++;
                $display("FAIL %s (cycle %0d, seen %0d): got %h expected %h",
                         mon_item.name, mon_item.cyc, cyc, act, mon_item.val);
            end
        end
        if (finish_req && sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    end

    task automatic expect_val(input kind_e kind, input logic [31:0] val, input string name);
        exp_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        csr_en = 1'b0; csr_op = 2'b00; csr_addr = 12'h0; csr_wdata = 32'h0;
        csr_no_wr = 1'b0; retire = 1'b0; trap_req = 1'b0; mret = 1'b0;
        trap_cause = 32'h0; trap_pc = 32'h0; trap_tval = 32'h0;
    endtask

    task automatic csr(input logic [1:0] op, input logic [11:0] addr,
                       input logic [31:0] wdata, input logic no_wr);
        csr_en = 1'b1; csr_op = op; csr_addr = addr; csr_wdata = wdata; csr_no_wr = no_wr;
    endtask

    task automatic csr_chk(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wdata,
                           input logic no_wr, input logic [31:0] exp_rd, input logic exp_ill,
                           input string name);
        next_cycle();
        csr(op, addr, wdata, no_wr);
        expect_val(K_RDATA, exp_rd, name);
        expect_val(K_ILL, {31'b0, exp_ill}, {name, "_ill"});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        next_cycle();
        next_cycle();
        next_cycle();
        rst = 1'b0;
        expect_val(K_MTVEC, MTVEC_RST, "reset_mtvec");
        expect_val(K_MEPC,  32'h0,     "reset_mepc");
        expect_val(K_MIE,   32'h0,     "reset_mie");
        expect_val(K_RDATA, 32'h0,     "idle_rdata");

        // Reset values; first mcycle increment on the first edge after release
        csr_chk(2'b00, 12'hB00, 32'h0, 1'b0, 32'h1,         1'b0, "mcycle_first");
        csr_chk(2'b00, 12'h300, 32'h0, 1'b0, 32'h0000_1800, 1'b0, "reset_mstatus");
        csr_chk(2'b00, 12'h301, 32'h0, 1'b0, 32'h4000_0100, 1'b0, "misa");
        csr_chk(2'b00, 12'hF14, 32'h0, 1'b0, HARTID,        1'b0, "mhartid_read");
        csr_chk(2'b00, 12'h305, 32'h0, 1'b0, MTVEC_RST,     1'b0, "reset_mtvec_rd");
        csr_chk(2'b00, 12'h123, 32'h0, 1'b0, 32'h0,         1'b1, "unimpl_addr");

        // mscratch write / no_wr set / set / clear
        csr_chk(2'b01, 12'h340, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0, "mscratch_rw");
        csr_chk(2'b10, 12'h340, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0, "mscratch_rs_nowr");
        csr_chk(2'b10, 12'h340, 32'h0000_00F0, 1'b0, 32'hDEAD_BEEF, 1'b0, "mscratch_set");
        csr_chk(2'b11, 12'h340, 32'hFFFF_0000, 1'b0, 32'hDEAD_BEFF, 1'b0, "mscratch_clr");
        csr_chk(2'b00, 12'h340, 32'h0,         1'b0, 32'h0000_BEFF, 1'b0, "mscratch_final");

        // mtvec alignment
        csr_chk(2'b01, 12'h305, 32'h0000_0103, 1'b0, MTVEC_RST, 1'b0, "mtvec_write");
        csr_chk(2'b00, 12'h305, 32'h0,         1'b0, 32'h0000_0100, 1'b0, "mtvec_rd");
        expect_val(K_MTVEC, 32'h0000_0100, "o_mtvec");

        // Trap entry
        csr_chk(2'b10, 12'h300, 32'h8, 1'b0, 32'h0000_1800, 1'b0, "mstatus_set_mie");
        next_cycle();
        expect_val(K_MIE, 32'h1, "mie_set");
        trap_req = 1'b1; trap_pc = 32'h0000_0042; trap_cause = 32'h2; trap_tval = 32'h0000_0013;
        csr_chk(2'b00, 12'h300, 32'h0, 1'b0, 32'h0000_1880, 1'b0, "trap_mstatus");
        expect_val(K_MEPC, 32'h0000_0040, "trap_o_mepc");
        expect_val(K_MIE,  32'h0,         "trap_mie");
        csr_chk(2'b00, 12'h342, 32'h0, 1'b0, 32'h2,         1'b0, "trap_mcause");
        csr_chk(2'b00, 12'h343, 32'h0, 1'b0, 32'h0000_0013, 1'b0, "trap_mtval");
        csr_chk(2'b00, 12'h341, 32'h0, 1'b0, 32'h0000_0040, 1'b0, "trap_mepc");

        // MRET
        next_cycle();
        mret = 1'b1;
        csr_chk(2'b00, 12'h300, 32'h0, 1'b0, 32'h0000_1888, 1'b0, "mret_mstatus");
        expect_val(K_MIE, 32'h1, "mret_mie");

        // Trap beats a same-cycle CSR write and MRET
        csr_chk(2'b01, 12'h340, 32'h1234_5678, 1'b0, 32'h0000_BEFF, 1'b0, "trap_rw_rdata");
        trap_req = 1'b1; mret = 1'b1; trap_pc = 32'h0000_0100; trap_cause = 32'h8000_0003;
        csr_chk(2'b00, 12'h340, 32'h0, 1'b0, 32'h0000_BEFF, 1'b0, "trap_drops_write");
        expect_val(K_MIE,  32'h0,         "trap2_mie");
        expect_val(K_MEPC, 32'h0000_0100, "trap2_o_mepc");
        csr_chk(2'b00, 12'h300, 32'h0, 1'b0, 32'h0000_1880, 1'b0, "trap2_mstatus");
        csr_chk(2'b00, 12'h342, 32'h0, 1'b0, 32'h8000_0003, 1'b0, "trap2_mcause");

        // Read-only and misa protection
        csr_chk(2'b01, 12'hF14, 32'h0, 1'b0, 32'h0,         1'b1, "mhartid_write");
        csr_chk(2'b10, 12'hF14, 32'h0, 1'b1, HARTID,        1'b0, "mhartid_rs_nowr");
        csr_chk(2'b01, 12'h301, 32'h0, 1'b0, 32'h0,         1'b1, "misa_write");
        csr_chk(2'b10, 12'h301, 32'h0, 1'b1, 32'h4000_0100, 1'b0, "misa_rs_nowr");

        // minstret
        csr_chk(2'b00, 12'hB02, 32'h0, 1'b0, 32'h0, 1'b0, "minstret_zero");
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            retire = 1'b1;
        end
        csr_chk(2'b00, 12'hB02, 32'h0, 1'b0, 32'h3, 1'b0, "minstret_3");
        retire = 1'b1;
        csr_chk(2'b00, 12'hB02, 32'h0, 1'b0, 32'h4, 1'b0, "minstret_4");
        csr_chk(2'b01, 12'hB02, 32'hA, 1'b0, 32'h4, 1'b0, "minstret_write");
        retire = 1'b1;
        csr_chk(2'b00, 12'hB02, 32'h0, 1'b0, 32'hA, 1'b0, "minstret_suppressed");
        csr_chk(2'b00, 12'hB82, 32'h0, 1'b0, 32'h0, 1'b0, "minstreth");

        // mcycle carry into the high half
        next_cycle();
        csr(2'b01, 12'hB00, 32'hFFFF_FFFF, 1'b0);
        csr_chk(2'b00, 12'hB80, 32'h0, 1'b0, 32'h0, 1'b0, "mcycleh_before_carry");
        csr_chk(2'b00, 12'hB00, 32'h0, 1'b0, 32'h0, 1'b0, "mcycle_wrapped");
        csr_chk(2'b00, 12'hB80, 32'h0, 1'b0, 32'h1, 1'b0, "mcycleh_carry");
        csr_chk(2'b01, 12'hB80, 32'h7, 1'b0, 32'h1, 1'b0, "mcycleh_write");
        csr_chk(2'b00, 12'hB80, 32'h0, 1'b0, 32'h7, 1'b0, "mcycleh_rd");

        // Asynchronous reset mid-run discards a same-cycle write
        csr_chk(2'b10, 12'h300, 32'h8, 1'b0, 32'h0000_1880, 1'b0, "pre_rst_mie");
        next_cycle();
        expect_val(K_MIE, 32'h1, "pre_rst_mie_out");
        next_cycle();
        csr(2'b01, 12'h340, 32'h0000_0055, 1'b0);
        #1;
        rst = 1'b1;
        expect_val(K_RDATA, 32'h0,     "rst_mscratch");
        expect_val(K_MTVEC, MTVEC_RST, "rst_o_mtvec");
        expect_val(K_MEPC,  32'h0,     "rst_o_mepc");
        expect_val(K_MIE,   32'h0,     "rst_o_mie");
        csr_chk(2'b00, 12'h300, 32'h0, 1'b0, 32'h0000_1800, 1'b0, "rst_mstatus");
        next_cycle();
        rst = 1'b0;
        csr_chk(2'b00, 12'hB00, 32'h0, 1'b0, 32'h1, 1'b0, "rst_mcycle_first");
        csr_chk(2'b00, 12'h340, 32'h0, 1'b0, 32'h0, 1'b0, "rst_dropped_write");

        next_cycle();
        finish_req = 1'b1;
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
